serial_port: RTL and testbench
==============================

# serial_port

Byte-wide UART for the CPUP serial path: 8 data bits, 1 stop bit, LSB first, with an optional even-parity bit. It is the line-side end of the IO controller's serial handshake. It accepts transmit bytes on a valid/ready pair and drives `txd`. It deserialises `rxd` into bytes presented on a valid/ready pair with an error flag. It sits between the IO controller and the board serial pins.

## Interface
Parameters:
- `CLK_HZ`, 50000000, system clock frequency.
- `BAUD`, 115200, line bit rate.
- `OVERSAMPLE`, 16, ticks per bit; must be even and ≥ 4.

Ports:
- `clock`  in  1  system clock, all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `soft_reset`  in  1  synchronous clear, driven by the IO controller's serial reset.
- `tx_data`  in  8  byte to transmit.
- `tx_valid`  in  1  `tx_data` valid.
- `tx_ready`  out  1  transmitter idle and able to accept a byte.
- `rx_data`  out  8  last received byte.
- `rx_valid`  out  1  `rx_data` holds an unconsumed byte.
- `rx_error`  out  1  error flag (framing, overrun, or parity) for the presented byte.
- `rx_ready`  in  1  consumer accepts `rx_data`.
- `txd`  out  1  serial line out; idle high.
- `rxd`  in  1  serial line in; asynchronous to `clock`.

## Operation
Tick generator:
- Counter runs 0..DIV-1, where DIV = round(CLK_HZ / (BAUD*OVERSAMPLE)).
- It emits a one-cycle `tick` on terminal count and is shared by TX and RX.

Transmitter FSM: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- `tx_ready` = 1 only in IDLE.
- A transfer occurs on a rising edge with `tx_valid && tx_ready`. That edge latches `tx_data` into the shift register and enters START.
- Each state lasts OVERSAMPLE ticks: START drives 0, DATA drives 8 bits LSB first, STOP drives 1.
- After STOP the FSM returns to IDLE, with `tx_ready` = 1 on the next cycle. Back-to-back bytes therefore add no idle bit.
- `tx_valid` while not ready is ignored; `tx_data` is not sampled.

Receiver FSM: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- `rxd` passes through a 2-flop synchronizer reset to 1.
- IDLE:
  - Entry: a synchronized falling edge moves to START and clears the tick count.
- START:
  - Sampled at tick OVERSAMPLE/2.
  - If the sample is 1, the start is false: return to IDLE with no output.
- DATA:
  - Each bit is sampled OVERSAMPLE ticks after the previous sample, i.e. at mid-bit.
  - Bits are shifted in LSB first.
- STOP:
  - Sampled at mid-bit; a 0 is a framing error.
  - The next cycle loads `rx_data` and sets `rx_valid` = 1.
  - `rx_error` is set to framing | overrun | parity.
  - The FSM then returns to IDLE. It hunts for the next start immediately and does not wait out the full stop bit.
- Output handshake:
  - `rx_valid` holds until a rising edge with `rx_valid && rx_ready`, which clears both `rx_valid` and `rx_error`.
- Overrun:
  - If a new byte completes while `rx_valid` = 1, the new byte overwrites `rx_data` and `rx_error` = 1.
  - If the consumer's handshake falls on the same edge as the overwrite, the new byte wins: `rx_valid` stays 1.

`soft_reset` and `reset_n` have identical effects:
- Both FSMs go to IDLE and the tick counter goes to 0.
- An in-flight TX frame is aborted and `txd` returns to 1.
- `soft_reset` has priority over any simultaneous handshake.

## Timing
- Reset values: `txd`=1, `tx_ready`=1, `rx_valid`=0, `rx_error`=0, `rx_data`=0x00.
- TX latency: `txd` falls within one tick of the accept edge.
- TX occupancy: `tx_ready` stays low for (10 [+1]) × OVERSAMPLE × DIV cycles, ±DIV cycles.
- RX latency: `rx_valid` rises 3 cycles after the stop-bit mid-sample edge on the pin (2 synchronizer cycles + 1 output register).
- All outputs are registered.

## Configuration
- `SERIAL_PARITY_EN` defined:
  - TX inserts an even-parity bit (XOR of the data bits) between DATA and STOP.
  - RX samples that bit; a mismatch sets `rx_error`.
  - The frame is 11 bits.
- `SERIAL_PARITY_EN` undefined:
  - No PARITY state; the frame is 10 bits.
  - The parity term of `rx_error` is constant 0.

## Structure
- Shared package `serial_pkg`: FSM state enum (IDLE, START, DATA, PARITY, STOP) and the DATA_BITS=8 constant.
- The DIV computation is a localparam derived from the parameters.
- One natural sub-module, `serial_baud_gen`: the tick counter, parameterised by DIV.
- TX and RX FSMs live in `serial_port`.

## Test plan
Bench uses CLK_HZ=6400, BAUD=100, OVERSAMPLE=16, giving DIV=4 and 64 cycles per bit.
- Reset: assert `reset_n`=0 mid-run → `txd`=1, `tx_ready`=1, `rx_valid`=0, `rx_error`=0 immediately.
- TX 0x55:
  - Stimulus: one-cycle `tx_valid` with `tx_data`=0x55.
  - Response: `txd` = 0,1,0,1,0,1,0,1,0,1, each 64±4 cycles.
  - `tx_ready` low ~640 cycles.
  - A second byte held valid is sent with no idle gap.
- RX 0xA3:
  - Stimulus: drive a correct frame on `rxd`.
  - Response: `rx_valid`=1, `rx_data`=0xA3, `rx_error`=0, held until `rx_ready` pulse, then both flags cleared.
- Framing: frame 0x3C with stop bit 0 → `rx_data`=0x3C, `rx_valid`=1, `rx_error`=1.
- Overrun / glitch:
  - Two frames 0x11 then 0x22 with `rx_ready`=0 → `rx_data`=0x22, `rx_error`=1.
  - `rxd` low for 20 cycles → no `rx_valid`.
- Parity (only with `SERIAL_PARITY_EN`):
  - TX 0x07 → parity bit 1.
  - RX 0x07 with parity 0 → `rx_error`=1.
  - `soft_reset` during TX → `txd`=1, `tx_ready`=1 next cycle.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: shared constants and types for the serial_port UART.
// Optional feature macro used by the design: SERIAL_PARITY_EN (even parity bit).
package serial_pkg;

    localparam int unsigned DATA_BITS = 8;

    // Frame phases shared by the TX and RX state machines
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } serialState_e;

    // Plain-vector state codes for the FSM registers
    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_START  = START;
    localparam logic [2:0] ST_DATA   = DATA;
    localparam logic [2:0] ST_PARITY = PARITY;
    localparam logic [2:0] ST_STOP   = STOP;

    // Rounded clock divider for one oversample tick, never below 1
    function automatic int unsigned calcDiv(input int unsigned clkHz,
                                            input int unsigned baud,
                                            input int unsigned oversample);
        int unsigned den;
        int unsigned div;
        den = baud * oversample;
        div = (clkHz + den / 2) / den;
        return (div == 0) ? 1 : div;
    endfunction

endpackage

// File: rtl/serial_baud_gen.sv
// serial_baud_gen: free-running oversample tick generator shared by TX and RX.
// Part of serial_port; SERIAL_PARITY_EN does not affect this block.
module serial_baud_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    // Count 0..DIV-1 and pulse tick for one cycle per wrap
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick  <= (count == CNT_LAST);
            count <= (count == CNT_LAST) ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_port.sv
// serial_port: byte-wide UART, 8N1 LSB first, valid/ready on both byte sides.
// Define SERIAL_PARITY_EN to add an even-parity bit between data and stop.
module serial_port
    import serial_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       soft_reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_error,
    input  logic       rx_ready,
    output logic       txd,
    input  logic       rxd
);

    localparam int unsigned DIV    = calcDiv(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
`ifdef SERIAL_PARITY_EN
    localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
`else
    localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif

    logic tick;

    serial_baud_gen #(
        .DIV(DIV)
    ) uBaudGen (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (soft_reset),
        .tick    (tick)
    );

    // ---------------- transmitter ----------------
    logic [2:0]           txState, txStateNxt;
    logic [TICK_W-1:0]    txTick, txTickNxt;
    logic [BIT_W-1:0]     txBit, txBitNxt;
    logic [DATA_BITS-1:0] txShift, txShiftNxt;
    logic                 txdQ, txdNxt;
    logic                 txReadyQ, txReadyNxt;
    logic                 txBitEnd;
`ifdef SERIAL_PARITY_EN
    logic                 txPar, txParNxt;
`endif

    // TX next state, shift and registered line/ready values
    always_comb begin
        txStateNxt = txState;
        txTickNxt  = txTick;
        txBitNxt   = txBit;
        txShiftNxt = txShift;
        txdNxt     = txdQ;
        txReadyNxt = txReadyQ;
`ifdef SERIAL_PARITY_EN
        txParNxt   = txPar;
`endif
        txBitEnd = tick && (txTick == TICK_LAST);
        if (tick) begin
            txTickNxt = txBitEnd ? '0 : txTick + TICK_W'(1);
        end

        case (txState)
            ST_IDLE: begin
                txTickNxt = '0;
                if (tx_valid && txReadyQ) begin
                    txStateNxt = ST_START;
                    txShiftNxt = tx_data;
                    txBitNxt   = '0;
`ifdef SERIAL_PARITY_EN
                    txParNxt   = ^tx_data;
`endif
                end
            end
            ST_START: begin
                if (txBitEnd) txStateNxt = ST_DATA;
            end
            ST_DATA: begin
                if (txBitEnd) begin
                    txShiftNxt = txShift >> 1;
                    if (txBit == BIT_LAST) begin
                        txBitNxt   = '0;
                        txStateNxt = ST_AFTER_DATA;
                    end else begin
                        txBitNxt = txBit + BIT_W'(1);
                    end
                end
            end
`ifdef SERIAL_PARITY_EN
            ST_PARITY: begin
                if (txBitEnd) txStateNxt = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (txBitEnd) txStateNxt = ST_IDLE;
            end
            default: txStateNxt = ST_IDLE;
        endcase

        // Line level follows the state being entered so txd is registered
        case (txStateNxt)
            ST_START:  txdNxt = 1'b0;
            ST_DATA:   txdNxt = txShiftNxt[0];
`ifdef SERIAL_PARITY_EN
            ST_PARITY: txdNxt = txParNxt;
`endif
            default:   txdNxt = 1'b1;
        endcase
        txReadyNxt = (txStateNxt == ST_IDLE);

        if (soft_reset) begin
            txStateNxt = ST_IDLE;
            txTickNxt  = '0;
            txBitNxt   = '0;
            txShiftNxt = '0;
            txdNxt     = 1'b1;
            txReadyNxt = 1'b1;
`ifdef SERIAL_PARITY_EN
            txParNxt   = 1'b0;
`endif
        end
    end

    // TX state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            txState  <= ST_IDLE;
            txTick   <= '0;
            txBit    <= '0;
            txShift  <= '0;
            txdQ     <= 1'b1;
            txReadyQ <= 1'b1;
`ifdef SERIAL_PARITY_EN
            txPar    <= 1'b0;
`endif
        end else begin
            txState  <= txStateNxt;
            txTick   <= txTickNxt;
            txBit    <= txBitNxt;
            txShift  <= txShiftNxt;
            txdQ     <= txdNxt;
            txReadyQ <= txReadyNxt;
`ifdef SERIAL_PARITY_EN
            txPar    <= txParNxt;
`endif
        end
    end

    assign txd      = txdQ;
    assign tx_ready = txReadyQ;

    // ---------------- receiver ----------------
    logic [1:0]           rxSync;
    logic                 rxS;
    logic                 rxPrev;
    logic [2:0]           rxState, rxStateNxt;
    logic [TICK_W-1:0]    rxTick, rxTickNxt;
    logic [BIT_W-1:0]     rxBit, rxBitNxt;
    logic [DATA_BITS-1:0] rxShift, rxShiftNxt;
    logic [DATA_BITS-1:0] rxDataQ, rxDataNxt;
    logic                 rxValidQ, rxValidNxt;
    logic                 rxErrorQ, rxErrorNxt;
    logic                 rxSample;
    logic                 rxParTerm;
`ifdef SERIAL_PARITY_EN
    logic                 rxParErr, rxParErrNxt;
`endif

    assign rxS = rxSync[1];

    // Two-flop synchronizer plus previous value for falling-edge detect
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rxSync <= 2'b11;
            rxPrev <= 1'b1;
        end else begin
            rxSync <= {rxSync[0], rxd};
            rxPrev <= rxS;
        end
    end

    // RX next state, mid-bit sampling and output handshake
    always_comb begin
        rxStateNxt = rxState;
        rxTickNxt  = rxTick;
        rxBitNxt   = rxBit;
        rxShiftNxt = rxShift;
        rxDataNxt  = rxDataQ;
        rxValidNxt = rxValidQ;
        rxErrorNxt = rxErrorQ;
        rxParTerm  = 1'b0;
`ifdef SERIAL_PARITY_EN
        rxParErrNxt = rxParErr;
        rxParTerm   = rxParErr;
`endif
        rxSample = tick && (rxTick == ((rxState == ST_START) ? TICK_HALF : TICK_LAST));
        if (tick) begin
            rxTickNxt = rxSample ? '0 : rxTick + TICK_W'(1);
        end

        if (rxValidQ && rx_ready) begin
            rxValidNxt = 1'b0;
            rxErrorNxt = 1'b0;
        end

        case (rxState)
            ST_IDLE: begin
                rxTickNxt = '0;
                if (rxPrev && !rxS) rxStateNxt = ST_START;
            end
            ST_START: begin
                if (rxSample) begin
                    if (rxS) begin
                        rxStateNxt = ST_IDLE;
                    end else begin
                        rxStateNxt = ST_DATA;
                        rxBitNxt   = '0;
`ifdef SERIAL_PARITY_EN
                        rxParErrNxt = 1'b0;
`endif
                    end
                end
            end
            ST_DATA: begin
                if (rxSample) begin
                    rxShiftNxt = {rxS, rxShift[DATA_BITS-1:1]};
                    if (rxBit == BIT_LAST) begin
                        rxStateNxt = ST_AFTER_DATA;
                    end else begin
                        rxBitNxt = rxBit + BIT_W'(1);
                    end
                end
            end
`ifdef SERIAL_PARITY_EN
            ST_PARITY: begin
                if (rxSample) begin
                    rxParErrNxt = rxS ^ (^rxShift);
                    rxStateNxt  = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // A completed byte always wins over a same-edge consume
                if (rxSample) begin
                    rxStateNxt = ST_IDLE;
                    rxDataNxt  = rxShift;
                    rxValidNxt = 1'b1;
                    rxErrorNxt = !rxS || rxValidQ || rxParTerm;
                end
            end
            default: rxStateNxt = ST_IDLE;
        endcase

        if (soft_reset) begin
            rxStateNxt = ST_IDLE;
            rxTickNxt  = '0;
            rxBitNxt   = '0;
            rxShiftNxt = '0;
            rxDataNxt  = '0;
            rxValidNxt = 1'b0;
            rxErrorNxt = 1'b0;
`ifdef SERIAL_PARITY_EN
            rxParErrNxt = 1'b0;
`endif
        end
    end

    // RX state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rxState  <= ST_IDLE;
            rxTick   <= '0;
            rxBit    <= '0;
            rxShift  <= '0;
            rxDataQ  <= '0;
            rxValidQ <= 1'b0;
            rxErrorQ <= 1'b0;
`ifdef SERIAL_PARITY_EN
            rxParErr <= 1'b0;
`endif
        end else begin
            rxState  <= rxStateNxt;
            rxTick   <= rxTickNxt;
            rxBit    <= rxBitNxt;
            rxShift  <= rxShiftNxt;
            rxDataQ  <= rxDataNxt;
            rxValidQ <= rxValidNxt;
            rxErrorQ <= rxErrorNxt;
`ifdef SERIAL_PARITY_EN
            rxParErr <= rxParErrNxt;
`endif
        end
    end

    assign rx_data  = rxDataQ;
    assign rx_valid = rxValidQ;
    assign rx_error = rxErrorQ;

endmodule

// File: tb/tb_serial_port.sv
// tb_serial_port: directed bench for serial_port at DIV=4, 64 cycles per bit.
// Honours SERIAL_PARITY_EN for frame length and parity vectors.
`timescale 1ns/1ps
module tb_serial_port;

    localparam int BIT_CYC = 64;
`ifdef SERIAL_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       soft_reset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    logic       rx_ready = 1'b0;
    logic       txd;
    logic       rxd = 1'b1;

    serial_port #(
        .CLK_HZ(6400),
        .BAUD(100),
        .OVERSAMPLE(16)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .soft_reset (soft_reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_error   (rx_error),
        .rx_ready   (rx_ready),
        .txd        (txd),
        .rxd        (rxd)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;     // line bits in send order, bit 0 = start
    } txVec_t;

    typedef struct {
        logic [7:0] data;
        logic       parBit;
        logic       stopBit;
        logic       consume;
        logic [7:0] expData;
        logic       expErr;
    } rxVec_t;

    int nChecks = 0;
    int nFail = 0;
    int cyc = 0;
    int acceptQ[$];
    txVec_t txVecs[$];
    rxVec_t rxVecs[$];

    // Cycle counter and log of TX handshake cycles
    always @(posedge clock) begin
        if (tx_valid && tx_ready) acceptQ.push_back(cyc);
        cyc <= cyc + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 3000000", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkRange(input string name, input int act, input int lo, input int hi);
        nChecks++;
        if (act < lo || act > hi) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic waitAccepts(input int n, output bit ok);
        int t;
        t = 0;
        while (acceptQ.size() < n && t < 3000) begin
            @(negedge clock);
            t++;
        end
        ok = (acceptQ.size() >= n);
        check($sformatf("tx accept count %0d", n), 32'(acceptQ.size() >= n), 32'd1);
    endtask

    task automatic checkTxFrame(input string name, input int acc, input logic [10:0] frame);
        for (int k = 0; k < FRAME_BITS; k++) begin
            while (cyc < acc + 1 + k * BIT_CYC + 30) @(negedge clock);
            check($sformatf("%s bit%0d", name, k), 32'(txd), 32'(frame[k]));
        end
    endtask

    task automatic checkOccupancy(input string name, input int acc);
        int t;
        t = 0;
        while (!tx_ready && t < 3000) begin
            @(negedge clock);
            t++;
        end
        checkRange($sformatf("%s tx_ready low cycles", name), cyc - (acc + 1),
                   FRAME_BITS * BIT_CYC - 4, FRAME_BITS * BIT_CYC + 4);
    endtask

    function automatic logic [10:0] mkRxFrame(input logic [7:0] d, input logic par, input logic stopb);
`ifdef SERIAL_PARITY_EN
        return {stopb, par, d, 1'b0};
`else
        return {par | 1'b1, stopb, d, 1'b0};
`endif
    endfunction

    task automatic sendRx(input logic [10:0] bits);
        for (int k = 0; k < FRAME_BITS; k++) begin
            rxd = bits[k];
            waitCycles(BIT_CYC);
        end
        rxd = 1'b1;
    endtask

    initial begin
        bit ok;
        int a;
        int b;
        logic [7:0] d;

`ifdef SERIAL_PARITY_EN
        txVecs.push_back('{8'h55, 11'h4AA});
        txVecs.push_back('{8'h07, 11'h60E});
        txVecs.push_back('{8'hC3, 11'h586});
`else
        txVecs.push_back('{8'h55, 11'h2AA});
        txVecs.push_back('{8'h07, 11'h20E});
        txVecs.push_back('{8'hC3, 11'h386});
`endif
        rxVecs.push_back('{8'hA3, 1'b0, 1'b1, 1'b1, 8'hA3, 1'b0});
        rxVecs.push_back('{8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1});
        rxVecs.push_back('{8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0});
        rxVecs.push_back('{8'h11, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0});
        rxVecs.push_back('{8'h22, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1});
`ifdef SERIAL_PARITY_EN
        rxVecs.push_back('{8'h07, 1'b0, 1'b1, 1'b1, 8'h07, 1'b1});
`endif

        // Power-on reset values
        waitCycles(3);
        check("reset txd", 32'(txd), 32'd1);
        check("reset tx_ready", 32'(tx_ready), 32'd1);
        check("reset rx_valid", 32'(rx_valid), 32'd0);
        check("reset rx_error", 32'(rx_error), 32'd0);
        check("reset rx_data", 32'(rx_data), 32'h00);
        reset_n = 1'b1;
        waitCycles(10);

        // Single TX bytes, including an ignored valid while busy
        foreach (txVecs[i]) begin
            acceptQ.delete();
            d = txVecs[i].data;
            tx_data  = d;
            tx_valid = 1'b1;
            @(negedge clock);
            tx_valid = 1'b0;
            check($sformatf("tx %02h ready low after accept", d), 32'(tx_ready), 32'd0);
            waitAccepts(1, ok);
            if (ok) begin
                a = acceptQ[0];
                waitCycles(20);
                tx_data  = ~d;
                tx_valid = 1'b1;
                @(negedge clock);
                tx_valid = 1'b0;
                tx_data  = d;
                checkTxFrame($sformatf("tx %02h", d), a, txVecs[i].frame);
                checkOccupancy($sformatf("tx %02h", d), a);
                check($sformatf("tx %02h busy valid ignored", d), 32'(acceptQ.size()), 32'd1);
            end
            waitCycles(10);
        end

        // Back-to-back TX with valid held: no idle bit between frames
        acceptQ.delete();
        tx_data  = txVecs[0].data;
        tx_valid = 1'b1;
        waitAccepts(1, ok);
        tx_data = txVecs[2].data;
        if (ok) begin
            a = acceptQ[0];
            checkTxFrame("b2b first", a, txVecs[0].frame);
            waitAccepts(2, ok);
            tx_valid = 1'b0;
            if (ok) begin
                b = acceptQ[1];
                checkRange("b2b accept spacing", b - a, FRAME_BITS * BIT_CYC - 4, FRAME_BITS * BIT_CYC + 5);
                checkTxFrame("b2b second", b, txVecs[2].frame);
                checkOccupancy("b2b second", b);
            end
        end
        tx_valid = 1'b0;
        waitCycles(10);

        // RX frames: good, framing error, overrun and parity cases
        foreach (rxVecs[i]) begin
            d = rxVecs[i].data;
            sendRx(mkRxFrame(d, rxVecs[i].parBit, rxVecs[i].stopBit));
            waitCycles(16);
            check($sformatf("rx %02h valid", d), 32'(rx_valid), 32'd1);
            check($sformatf("rx %02h data", d), 32'(rx_data), 32'(rxVecs[i].expData));
            check($sformatf("rx %02h error", d), 32'(rx_error), 32'(rxVecs[i].expErr));
            waitCycles(BIT_CYC);
            if (rxVecs[i].consume) begin
                check($sformatf("rx %02h valid held", d), 32'(rx_valid), 32'd1);
                rx_ready = 1'b1;
                @(negedge clock);
                rx_ready = 1'b0;
                check($sformatf("rx %02h valid cleared", d), 32'(rx_valid), 32'd0);
                check($sformatf("rx %02h error cleared", d), 32'(rx_error), 32'd0);
            end
        end

        // Short low glitch on rxd is a false start
        rxd = 1'b0;
        waitCycles(20);
        rxd = 1'b1;
        waitCycles(300);
        check("glitch rx_valid", 32'(rx_valid), 32'd0);

        // Asynchronous reset mid-run with TX busy and an unconsumed RX byte
        sendRx(mkRxFrame(8'h5A, 1'b0, 1'b1));
        waitCycles(16);
        check("pre-reset rx_valid", 32'(rx_valid), 32'd1);
        check("pre-reset rx_data", 32'(rx_data), 32'h5A);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        waitCycles(200);
        check("pre-reset tx_ready", 32'(tx_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        check("async reset txd", 32'(txd), 32'd1);
        check("async reset tx_ready", 32'(tx_ready), 32'd1);
        check("async reset rx_valid", 32'(rx_valid), 32'd0);
        check("async reset rx_error", 32'(rx_error), 32'd0);
        check("async reset rx_data", 32'(rx_data), 32'h00);
        waitCycles(3);
        reset_n = 1'b1;
        waitCycles(10);

        // Soft reset aborts an in-flight TX frame
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        waitCycles(200);
        check("soft pre txd", 32'(txd), 32'd0);
        check("soft pre tx_ready", 32'(tx_ready), 32'd0);
        soft_reset = 1'b1;
        @(negedge clock);
        soft_reset = 1'b0;
        check("soft reset txd", 32'(txd), 32'd1);
        check("soft reset tx_ready", 32'(tx_ready), 32'd1);
        waitCycles(100);
        check("soft reset txd idle", 32'(txd), 32'd1);
        check("soft reset tx_ready idle", 32'(tx_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
